imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter DEPTH, default 1024, words in the target instruction memory.
REQ-002 Parameter ADDR_W, default 10, word-address width; DEPTH = 2**ADDR_W.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle pulse that begins a load session.
REQ-006 rx_data  input  8  incoming byte from the boot stream.
REQ-007 rx_valid  input  1  rx_data is valid this cycle.
REQ-008 rx_ready  output  1  loader accepts a byte this cycle.
REQ-009 mem_we  output  1  instruction-memory word write strobe.
REQ-010 mem_addr  output  ADDR_W  word address of the write.
REQ-011 mem_wdata  output  32  instruction word to write.
REQ-012 cpu_hold  output  1  holds the CPU in reset while no valid program is loaded.
REQ-013 busy  output  1  a session is in progress.
REQ-014 done  output  1  last session completed with a good checksum.
REQ-015 error  output  1  last session failed on length or checksum.
REQ-016 words_loaded  output  ADDR_W+1  count of words written in the current or last session.

Function
REQ-017 A byte SHALL be accepted only on a cycle where rx_valid and rx_ready are both 1.
REQ-018 Stream format SHALL be: 4-byte little-endian word count N; N words of 4 bytes each, little-endian; 1 checksum byte equal to the XOR of all payload bytes (the header is excluded).
REQ-019 FSM states SHALL be IDLE, LEN, DATA, CSUM, DONE and ERR.
REQ-020 IDLE/DONE/ERR -> LEN on start; on that transition done, error, words_loaded and the checksum accumulator SHALL clear.
REQ-021 start SHALL be ignored while in LEN, DATA or CSUM.
REQ-022 rx_ready SHALL be 1 exactly in LEN, DATA and CSUM; busy SHALL equal rx_ready.
REQ-023 LEN -> DATA after the 4th header byte if 1 <= N <= DEPTH; otherwise LEN -> ERR.
REQ-024 In DATA, a 2-bit byte-lane counter SHALL place each byte at bits [8*lane+7:8*lane] and wrap from 3 to 0.
REQ-025 On the cycle after the 4th byte of a word is accepted, mem_we SHALL be 1 for exactly one cycle, with mem_addr = word index (starting at 0) and mem_wdata = the assembled word; words_loaded SHALL increment in that same cycle.
REQ-026 DATA -> CSUM when the 4th byte of word N-1 is accepted.
REQ-027 CSUM -> DONE if the received byte equals the accumulator; otherwise CSUM -> ERR.
REQ-028 done SHALL be 1 in DONE only; error SHALL be 1 in ERR only.
REQ-029 cpu_hold SHALL be 1 in every state except DONE.
REQ-030 Gaps in rx_valid SHALL stall progress without corrupting the lane counter, the word or the checksum.
REQ-031 mem_we SHALL never be asserted outside the write cycle defined in REQ-025.

Reset
REQ-032 reset SHALL force state IDLE, rx_ready=0, busy=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=1, done=0, error=0, words_loaded=0, lane counter 0 and accumulator 0.
REQ-033 reset SHALL take priority over start and over rx_valid in the same cycle.
REQ-034 reset in the middle of a session SHALL abandon the session, and no further mem_we SHALL occur.

Structure
REQ-035 The shared package SHALL hold the FSM state encoding and the default values of DEPTH and ADDR_W.
REQ-036 Byte-to-word assembly with the lane counter SHALL be one sub-module, imem_word_packer.

Verification
REQ-037 start, then bytes 02 00 00 00 13 00 00 00 93 00 50 00 D0 -> writes addr0=0x00000013 and addr1=0x00500093; done=1, cpu_hold=0, words_loaded=2.
REQ-038 Same stream with the checksum byte 0xD1 -> both words are written; error=1, done=0, cpu_hold=1.
REQ-039 Header 00 00 00 00, and separately header 01 04 00 00 (N=1025) -> ERR right after the 4th byte; no mem_we; rx_ready=0.
REQ-040 REQ-037 stream with rx_valid low for 3 cycles between every byte -> identical writes and final flags.
REQ-041 reset asserted after the 6th byte of the REQ-037 stream -> all outputs at their reset values the next cycle; no mem_we afterwards; start is accepted again.
REQ-042 start pulsed while in DATA -> ignored, and the session completes as in REQ-037.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the boot-stream instruction-memory loader:
// FSM encoding, default geometry and the checksum update helper.
package imem_loader_pkg;

  localparam int DEFAULT_ADDR_W = 10;
  localparam int DEFAULT_DEPTH  = 1024;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LEN  = 3'd1,
    ST_DATA = 3'd2,
    ST_CSUM = 3'd3,
    ST_DONE = 3'd4,
    ST_ERR  = 3'd5
  } state_e;

  function automatic logic [7:0] csum_update(input logic [7:0] acc, input logic [7:0] data);
    return acc ^ data;
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
// master = the loader, slave = the byte source / memory side.
interface imem_loader_if
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W
) ();
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  modport master (
    input  rx_data, rx_valid,
    output rx_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output rx_data, rx_valid,
    input  rx_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_word_packer.sv
// Little-endian byte-to-word assembler with a wrapping 2-bit lane counter.
// word presents the completed word combinationally on the cycle word_done fires.
module imem_word_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [7:0]  byte_in,
  output logic        word_done,
  output logic [31:0] word
);

  logic [1:0]  lane_q, lane_d;
  logic [31:0] word_q, word_d;

  // Next lane and partial word
  always_comb begin
    lane_d = lane_q;
    word_d = word_q;
    if (clear) begin
      lane_d = 2'd0;
      word_d = 32'd0;
    end else if (byte_en) begin
      case (lane_q)
        2'd0:    word_d[7:0]   = byte_in;
        2'd1:    word_d[15:8]  = byte_in;
        2'd2:    word_d[23:16] = byte_in;
        default: word_d[31:24] = byte_in;
      endcase
      lane_d = lane_q + 2'd1;
    end else begin
      lane_d = lane_q;
      word_d = word_q;
    end
  end

  // Lane and word registers
  always_ff @(posedge clk) begin
    if (reset) begin
      lane_q <= 2'd0;
      word_q <= 32'd0;
    end else begin
      lane_q <= lane_d;
      word_q <= word_d;
    end
  end

  assign word_done = byte_en && !clear && (lane_q == 2'd3);
  assign word      = word_d;

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses a length-prefixed, XOR-checksummed byte stream and
// writes it word by word into instruction memory, holding the CPU until done.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  imem_loader_if.master   bus,
  output logic            cpu_hold,
  output logic            busy,
  output logic            done,
  output logic            error,
  output logic [ADDR_W:0] words_loaded
);

  localparam logic [ADDR_W:0] ONE_W = (ADDR_W + 1)'(1);

  state_e            state_q, state_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [7:0]        acc_q, acc_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;

  logic        rx_ready_s;
  logic        accept_s;
  logic        start_ok_s;
  logic        pack_en_s;
  logic        word_done_s;
  logic [31:0] word_s;

  assign rx_ready_s = (state_q == ST_LEN) || (state_q == ST_DATA) || (state_q == ST_CSUM);
  assign accept_s   = bus.rx_valid && rx_ready_s;
  assign start_ok_s = start && !rx_ready_s;
  assign pack_en_s  = accept_s && ((state_q == ST_LEN) || (state_q == ST_DATA));

  // The header length word is assembled by the same packer as the payload.
  imem_word_packer u_packer (
    .clk       (clk),
    .reset     (reset),
    .clear     (start_ok_s),
    .byte_en   (pack_en_s),
    .byte_in   (bus.rx_data),
    .word_done (word_done_s),
    .word      (word_s)
  );

  // Next-state, checksum and write-port logic
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start_ok_s) begin
          state_d = ST_LEN;
          cnt_d   = '0;
          acc_d   = 8'd0;
        end else begin
          state_d = state_q;
        end
      end
      ST_LEN: begin
        if (word_done_s) begin
          if ((word_s >= 32'd1) && (word_s <= 32'(DEPTH))) begin
            state_d = ST_DATA;
            len_d   = word_s[ADDR_W:0];
          end else begin
            state_d = ST_ERR;
          end
        end else begin
          state_d = ST_LEN;
        end
      end
      ST_DATA: begin
        if (accept_s) begin
          acc_d = csum_update(acc_q, bus.rx_data);
          if (word_done_s) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = cnt_q[ADDR_W-1:0];
            mem_wdata_d = word_s;
            cnt_d       = cnt_q + ONE_W;
            state_d     = (cnt_q == len_q - ONE_W) ? ST_CSUM : ST_DATA;
          end else begin
            state_d = ST_DATA;
          end
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_CSUM: begin
        if (accept_s) begin
          state_d = (bus.rx_data == acc_q) ? ST_DONE : ST_ERR;
        end else begin
          state_d = ST_CSUM;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      cnt_q       <= '0;
      acc_q       <= 8'd0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign bus.rx_ready  = rx_ready_s;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign busy          = rx_ready_s;
  assign done          = (state_q == ST_DONE);
  assign error         = (state_q == ST_ERR);
  assign cpu_hold      = (state_q != ST_DONE);
  assign words_loaded  = cnt_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected memory writes are queued as
// stream bytes are driven and matched against mem_we cycles.
module tb_imem_loader;

  localparam int ADDR_W = 10;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic            cpu_hold;
  logic            busy;
  logic            done;
  logic            error;
  logic [ADDR_W:0] words_loaded;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [7:0]  stream[$];
  logic [41:0] exp_q[$];
  logic [41:0] mon_e;

  imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_loader #(.DEPTH(1024), .ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .bus          (bus),
    .cpu_hold     (cpu_hold),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // write monitor: every mem_we must match the head of the scoreboard
  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_val("spurious_we", 64'(bus.mem_we), 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check_val("wr_addr", 64'(bus.mem_addr), 64'(mon_e[41:32]));
        check_val("wr_data", 64'(bus.mem_wdata), 64'(mon_e[31:0]));
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap, input bit pulse_start);
    int guard;
    bus.rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    start        = pulse_start;
    guard        = 0;
    while (bus.rx_ready !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) check_val("ready_timeout", 64'(bus.rx_ready), 64'd1);
    @(negedge clk);
    bus.rx_valid = 1'b0;
    start        = 1'b0;
  endtask

  task automatic run_stream(input int gap, input int mid_start_at);
    logic [31:0] n;
    logic [31:0] w;
    n = 32'd0;
    w = 32'd0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_val("busy_after_start", 64'(busy), 64'd1);
    check_val("wl_cleared", 64'(words_loaded), 64'd0);
    check_val("done_cleared", 64'(done), 64'd0);
    check_val("error_cleared", 64'(error), 64'd0);
    for (int i = 0; i < stream.size(); i++) begin
      if (i < 4) begin
        n[8*i +: 8] = stream[i];
      end else if ((i - 4) < 4 * int'(n)) begin
        w[8*((i-4)%4) +: 8] = stream[i];
        if ((i - 4) % 4 == 3) exp_q.push_back({10'((i - 4) / 4), w});
      end
      send_byte(stream[i], gap, i == mid_start_at);
    end
  endtask

  task automatic check_end(input bit exp_done, input bit exp_err, input int exp_wl);
    check_val("done", 64'(done), 64'(exp_done));
    check_val("error", 64'(error), 64'(exp_err));
    check_val("cpu_hold", 64'(cpu_hold), 64'(!exp_done));
    check_val("words_loaded", 64'(words_loaded), 64'(exp_wl));
    check_val("rx_ready_end", 64'(bus.rx_ready), 64'd0);
    check_val("busy_end", 64'(busy), 64'd0);
    repeat (2) @(negedge clk);
    check_val("sb_empty", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_rx_ready"}, 64'(bus.rx_ready), 64'd0);
    check_val({tag, "_busy"}, 64'(busy), 64'd0);
    check_val({tag, "_mem_we"}, 64'(bus.mem_we), 64'd0);
    check_val({tag, "_mem_addr"}, 64'(bus.mem_addr), 64'd0);
    check_val({tag, "_mem_wdata"}, 64'(bus.mem_wdata), 64'd0);
    check_val({tag, "_cpu_hold"}, 64'(cpu_hold), 64'd1);
    check_val({tag, "_done"}, 64'(done), 64'd0);
    check_val({tag, "_error"}, 64'(error), 64'd0);
    check_val({tag, "_wl"}, 64'(words_loaded), 64'd0);
  endtask

  initial begin
    reset        = 1'b1;
    start        = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'd0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    reset = 1'b0;

    // good two-word program
    stream = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
               8'h93, 8'h00, 8'h50, 8'h00, 8'hD0};
    run_stream(0, -1);
    check_end(1'b1, 1'b0, 2);

    // bad checksum: words still written
    stream[12] = 8'hD1;
    run_stream(0, -1);
    check_end(1'b0, 1'b1, 2);

    // zero-length header
    stream = '{8'h00, 8'h00, 8'h00, 8'h00};
    run_stream(0, -1);
    check_end(1'b0, 1'b1, 0);

    // N = 1025 exceeds depth
    stream = '{8'h01, 8'h04, 8'h00, 8'h00};
    run_stream(0, -1);
    check_end(1'b0, 1'b1, 0);

    // good program with 3-cycle gaps between bytes
    stream = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
               8'h93, 8'h00, 8'h50, 8'h00, 8'hD0};
    run_stream(3, -1);
    check_end(1'b1, 1'b0, 2);

    // start pulsed during DATA is ignored
    run_stream(0, 6);
    check_end(1'b1, 1'b0, 2);

    // reset after the 6th byte, together with start and rx_valid
    stream = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00};
    run_stream(0, -1);
    reset        = 1'b1;
    start        = 1'b1;
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'h55;
    @(negedge clk);
    check_reset_outputs("midrst");
    reset = 1'b0;
    start = 1'b0;
    repeat (6) @(negedge clk);
    bus.rx_valid = 1'b0;
    check_val("idle_after_rst", 64'(busy), 64'd0);

    // loader accepts a new session afterwards
    stream = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
               8'h93, 8'h00, 8'h50, 8'h00, 8'hD0};
    run_stream(0, -1);
    check_end(1'b1, 1'b0, 2);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
